// File: rtl/lutram_selftest_pkg.sv
// rtl/lutram_selftest_pkg.sv - shared types, pattern codes and pattern generator for the LUTRAM march tester
// Purpose: FSM state encoding, data-pattern mode codes and the pattern(addr) function.
// Ports: none (package).
package lutram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_VERIFY0 = 3'd2,
    ST_WRITE   = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] PAT_ADDR0   = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_ADDR    = 2'd2;
  localparam logic [1:0] PAT_NADDR   = 2'd3;

  // Returns the expected word for an address, masked to dw bits.
  function automatic logic [31:0] pattern(input logic [1:0] mode,
                                          input logic [31:0] addr,
                                          input int unsigned dw);
    logic [31:0] p;
    logic [31:0] mask;
    case (mode)
      PAT_ADDR0:   p = {32{addr[0]}};
      // bit i = i[0] ^ addr[0]: even addresses set the odd bits
      PAT_CHECKER: p = addr[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      PAT_ADDR:    p = addr;
      default:     p = ~addr;
    endcase
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    return p & mask;
  endfunction

endpackage

// File: rtl/lutram_selftest_if.sv
// rtl/lutram_selftest_if.sv - control/status bundle of the LUTRAM march tester
// Purpose: groups run control inputs and status outputs.
// Ports: start_i, mode_i, inject_i (master -> slave); q_o, busy_o, done_o,
//        pass_o, err_count_o, first_err_addr_o (slave -> master).
interface lutram_selftest_if #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 1,
  parameter int ERR_W   = A_WIDTH + 2
);
  logic               start_i;
  logic [1:0]         mode_i;
  logic               inject_i;
  logic [D_WIDTH-1:0] q_o;
  logic               busy_o;
  logic               done_o;
  logic               pass_o;
  logic [ERR_W-1:0]   err_count_o;
  logic [A_WIDTH-1:0] first_err_addr_o;

  modport master (
    output start_i, mode_i, inject_i,
    input  q_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o
  );

  modport slave (
    input  start_i, mode_i, inject_i,
    output q_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o
  );
endinterface

// File: rtl/lutram_sp.sv
// rtl/lutram_sp.sv - single-port distributed RAM, synchronous write, asynchronous read
// Purpose: inferred LUTRAM under test.
// Ports: clk_i clock; we write enable; addr word address; d write data; q read data.
module lutram_sp #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               we,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH-1:0] q
);

  // Asynchronous read keeps this in LUT fabric; block RAM cannot read combinationally.
  (* ram_style = "distributed" *) logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= d;
  end

  assign q = mem[addr];

endmodule

// File: rtl/lutram_selftest.sv
// rtl/lutram_selftest.sv - parametrised LUTRAM march tester with compare, error count and fault inject
// Purpose: walks CLEAR, VERIFY0, WRITE, READ over the RAM, one address per divider tick.
// Ports: clk_i clock; rst_i synchronous active-high reset; bus status/control bundle.
module lutram_selftest
  import lutram_test_pkg::*;
#(
  parameter int          A_WIDTH         = 6,
  parameter int          D_WIDTH         = 1,
  parameter logic [31:0] DIV_COUNTER_END = 32'h00FF_FFFF,
  parameter int          ERR_W           = A_WIDTH + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lutram_selftest_if.slave bus
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]        div_q, div_d;
  logic [1:0]         mode_q, mode_d;
  logic               inject_q, inject_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [A_WIDTH-1:0] first_q, first_d;

  logic               tick;
  logic               last;
  logic               we;
  logic [31:0]        pat32;
  logic [D_WIDTH-1:0] pat;
  logic [D_WIDTH-1:0] wdata;
  logic [D_WIDTH-1:0] exp_data;
  logic [D_WIDTH-1:0] ram_q;

  lutram_sp #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
    .clk_i (clk_i),
    .we    (we),
    .addr  (addr_q),
    .d     (wdata),
    .q     (ram_q)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    div_d    = div_q;
    mode_d   = mode_q;
    inject_d = inject_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    first_d  = first_q;

    tick  = (div_q == DIV_COUNTER_END);
    last  = (addr_q == {A_WIDTH{1'b1}});
    pat32 = pattern(mode_q, 32'(addr_q), D_WIDTH);
    pat   = pat32[D_WIDTH-1:0];

    we    = tick && (state_q == ST_CLEAR || state_q == ST_WRITE);
    wdata = '0;
    if (state_q == ST_WRITE) begin
      // Injected fault: one flipped bit at address 0 gives exactly one READ miss.
      wdata = pat ^ ((inject_q && addr_q == '0) ? D_WIDTH'(1) : '0);
    end
    exp_data = (state_q == ST_READ) ? pat : '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          mode_d   = bus.mode_i;
          inject_d = bus.inject_i;
          addr_d   = '0;
          div_d    = '0;
          err_d    = '0;
          first_d  = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR, ST_VERIFY0, ST_WRITE, ST_READ: begin
        div_d = tick ? '0 : div_q + 32'd1;
        if (tick) begin
          addr_d = addr_q + 1'b1;  // wraps to 0 after the last address
          if ((state_q == ST_VERIFY0 || state_q == ST_READ) && ram_q != exp_data) begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
            // A saturating count never returns to zero, so zero means no miss yet.
            if (err_q == '0) first_d = addr_q;
          end
          if (last) begin
            case (state_q)
              ST_CLEAR:   state_d = ST_VERIFY0;
              ST_VERIFY0: state_d = ST_WRITE;
              ST_WRITE:   state_d = ST_READ;
              default: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Uses next-state values so pass rises on the same edge as done.
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      div_q    <= '0;
      mode_q   <= '0;
      inject_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      inject_q <= inject_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign bus.q_o              = ram_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.pass_o           = pass_q;
  assign bus.err_count_o      = err_q;
  assign bus.first_err_addr_o = first_q;

endmodule
